regfile_mp: RTL and testbench

//   Parametrised multi-read-port integer register file with write-to-read bypass,
//   per-register pending scoreboard and a sequential clear engine. Successor to the
//   2R1W file in the decode stage. Serves NRD operand reads per cycle, tracks
//   in-flight destinations for hazard checks and wipes the file on flush without reset.

---
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-to-read bypass, a pending-destination
// scoreboard and a one-register-per-cycle clear engine for pipeline flushes.
module regfile_mp #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [XLEN-1:0]      wr_data,
    output logic                 wr_ready,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 clr_req,
    output logic                 clr_busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_idx;
    logic [XLEN-1:0]   r_regs [NREGS];
    logic [NREGS-1:0]  r_pend;

    logic              w_idle;
    logic              w_wr_acc;

    // Outputs are gated by rst so nothing leaks while reset is held.
    assign w_idle   = (r_state == ST_IDLE);
    assign wr_ready = !rst && w_idle;
    assign clr_busy = !rst && (r_state == ST_CLEAR);
    assign w_wr_acc = wr_en && wr_ready && (wr_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= AW'(1);
            r_pend  <= '0;
            // NOTE: the array is plain flops and is reset explicitly so no X can ever reach rd_data.
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_acc) begin
                        r_regs[wr_addr] <= wr_data;
                    end
                    if (clr_req) begin
                        r_state <= ST_CLEAR;
                        r_pend  <= '0;
                    end else begin
                        if (w_wr_acc) begin
                            r_pend[wr_addr] <= 1'b0;
                        end
                        // Later assignment wins: a new producer overrides a retiring one.
                        if (iss_en && (iss_addr != '0)) begin
                            r_pend[iss_addr] <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    r_regs[r_idx] <= '0;
                    if (r_idx == AW'(NREGS - 1)) begin
                        r_state <= ST_IDLE;
                        r_idx   <= AW'(1);
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_hit;
        logic          w_byp;

        assign w_addr = rd_addr[p*AW +: AW];
        assign w_hit  = !rst && rd_en[p] && (w_addr != '0);
        assign w_byp  = w_wr_acc && (wr_addr == w_addr);

        assign rd_data[p*XLEN +: XLEN] = !w_hit ? '0 :
                                         w_byp  ? wr_data : r_regs[w_addr];
        assign rd_busy[p] = w_hit && !w_byp && w_idle && r_pend[w_addr];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, clear/reset sequences,
// and randomized traffic against an array/queue reference model.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = $clog2(NREGS);

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                wr_ready;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                clr_req;
    logic                clr_busy;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .clr_req  (clr_req),
        .clr_busy (clr_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: register contents, pending flags, and the list of
    // registers the clear engine still has to wipe (non-empty = clearing).
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_pend [NREGS];
    int              clr_q [$];

    typedef struct {
        logic           wr_en;
        logic [AW-1:0]  wr_addr;
        logic [XLEN-1:0] wr_data;
        logic           iss_en;
        logic [AW-1:0]  iss_addr;
        logic [NRD-1:0] rd_en;
        logic [AW-1:0]  a0;
        logic [AW-1:0]  a1;
        logic [XLEN-1:0] d0;
        logic [XLEN-1:0] d1;
        logic [NRD-1:0] busy;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        clr_q.delete();
    endtask

    task automatic model_edge();
        int  a;
        bit  acc;
        if (rst) return;
        if (clr_q.size() > 0) begin
            a = clr_q.pop_front();
            m_regs[a] = '0;
        end else begin
            acc = wr_en && (wr_addr != '0);
            if (acc) m_regs[wr_addr] = wr_data;
            if (clr_req) begin
                for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
                for (int i = 1; i < NREGS; i++) clr_q.push_back(i);
            end else begin
                if (acc) m_pend[wr_addr] = 1'b0;
                if (iss_en && (iss_addr != '0)) m_pend[iss_addr] = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        bit              clr;
        bit              acc;
        logic [AW-1:0]   a;
        logic [XLEN-1:0] ed;
        logic            eb;
        clr = (clr_q.size() > 0);
        acc = !rst && wr_en && !clr && (wr_addr != '0);
        check({tag, ".wr_ready"}, XLEN'(wr_ready), XLEN'(!rst && !clr));
        check({tag, ".clr_busy"}, XLEN'(clr_busy), XLEN'(!rst && clr));
        for (int p = 0; p < NRD; p++) begin
            a  = rd_addr[p*AW +: AW];
            ed = '0;
            eb = 1'b0;
            if (!rst && rd_en[p] && (a != '0)) begin
                if (acc && (wr_addr == a)) begin
                    ed = wr_data;
                end else begin
                    ed = m_regs[a];
                    eb = !clr && m_pend[a];
                end
            end
            check($sformatf("%s.rd_data%0d", tag, p), rd_data[p*XLEN +: XLEN], ed);
            check($sformatf("%s.rd_busy%0d", tag, p), XLEN'(rd_busy[p]), XLEN'(eb));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        rd_en    = '0;
        rd_addr  = '0;
        clr_req  = 1'b0;
    endtask

    task automatic read_all_zero(input string tag);
        for (int r = 0; r < NREGS; r += 2) begin
            rd_en   = '1;
            rd_addr = {AW'(r + 1), AW'(r)};
            #3;
            check($sformatf("%s.r%0d", tag, r),     rd_data[0 +: XLEN],    '0);
            check($sformatf("%s.r%0d", tag, r + 1), rd_data[XLEN +: XLEN], '0);
            tick();
        end
        set_idle();
    endtask

    initial begin
        int cnt;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;

        // wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_en, a0, a1, d0, d1, busy
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 2'b00, 5'd5, 5'd0, 32'h0,        32'h0,    2'b00};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 2'b11, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,    2'b00};
        vecs[2] = '{1'b1, 5'd7, 32'h1234,     1'b0, 5'd0, 2'b11, 5'd5, 5'd7, 32'hDEADBEEF, 32'h1234, 2'b00};
        vecs[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 2'b11, 5'd0, 5'd0, 32'h0,        32'h0,    2'b00};
        vecs[4] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 2'b11, 5'd0, 5'd0, 32'h0,        32'h0,    2'b00};
        vecs[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 2'b11, 5'd3, 5'd3, 32'h0,        32'h0,    2'b11};
        vecs[6] = '{1'b1, 5'd3, 32'h9,        1'b0, 5'd0, 2'b11, 5'd3, 5'd7, 32'h9,        32'h1234, 2'b00};
        vecs[7] = '{1'b1, 5'd3, 32'hA,        1'b1, 5'd3, 2'b11, 5'd3, 5'd5, 32'hA,        32'hDEADBEEF, 2'b00};
        vecs[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 2'b01, 5'd3, 5'd3, 32'hA,        32'h0,    2'b01};

        // Reset with active inputs: every output must be forced to zero.
        set_idle();
        model_reset();
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'h5555AAAA;
        rd_en   = '1;
        rd_addr = {5'd5, 5'd5};
        #3;
        check_model("reset");
        set_idle();
        #4 rst = 1'b0;
        #1;
        check_model("post_reset");
        tick();

        // Directed vectors: write/read, bypass, r0 rules, scoreboard.
        for (int i = 0; i < 9; i++) begin
            wr_en    = vecs[i].wr_en;
            wr_addr  = vecs[i].wr_addr;
            wr_data  = vecs[i].wr_data;
            iss_en   = vecs[i].iss_en;
            iss_addr = vecs[i].iss_addr;
            rd_en    = vecs[i].rd_en;
            rd_addr  = {vecs[i].a1, vecs[i].a0};
            #3;
            check($sformatf("vec%0d.d0", i), rd_data[0 +: XLEN],    vecs[i].d0);
            check($sformatf("vec%0d.d1", i), rd_data[XLEN +: XLEN], vecs[i].d1);
            check($sformatf("vec%0d.busy", i), XLEN'(rd_busy), XLEN'(vecs[i].busy));
            tick();
        end
        set_idle();

        // Fill r1..r31 with nonzero data, then clear with a concurrent write.
        for (int r = 1; r < NREGS; r++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(r);
            wr_data = $urandom | 32'h1;
            iss_en  = 1'b1;
            iss_addr = AW'(NREGS - r);
            #3;
            check_model("fill");
            tick();
        end
        set_idle();
        clr_req = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'h0BADF00D;
        #3;
        check_model("clr_start");
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < NREGS - 1; k++) begin
            wr_en   = 1'b1;
            wr_addr = AW'($urandom);
            wr_data = $urandom;
            iss_en  = 1'b1;
            iss_addr = AW'($urandom);
            clr_req = (k == 5);
            rd_en   = '1;
            rd_addr = {AW'(NREGS - 1), AW'($urandom)};
            #3;
            check($sformatf("clr%0d.busy", k),  XLEN'(clr_busy), XLEN'(1));
            check($sformatf("clr%0d.ready", k), XLEN'(wr_ready), XLEN'(0));
            check_model("clearing");
            tick();
        end
        set_idle();
        #3;
        check("clr_done.busy", XLEN'(clr_busy), XLEN'(0));
        check("clr_done.ready", XLEN'(wr_ready), XLEN'(1));
        read_all_zero("after_clr");

        // Reset in the middle of a clear aborts it at once.
        for (int r = 1; r < 8; r++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(r * 3);
            wr_data = $urandom | 32'h1;
            #3;
            tick();
        end
        set_idle();
        clr_req = 1'b1;
        #3;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rst_mid.busy", XLEN'(clr_busy), XLEN'(0));
        check_model("rst_mid");
        #3 rst = 1'b0;
        tick();
        read_all_zero("after_rst");
        clr_req = 1'b1;
        #3;
        tick();
        clr_req = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100 && clr_busy; k++) begin
            cnt++;
            #3;
            check_model("reclear");
            tick();
        end
        check("reclear.cycles", XLEN'(cnt), XLEN'(NREGS - 1));

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom);
            wr_data  = $urandom;
            iss_en   = ($urandom_range(0, 2) == 0);
            iss_addr = AW'($urandom);
            clr_req  = ($urandom_range(0, 99) == 0);
            if (clr_req) iss_en = 1'b0;
            rd_en    = NRD'($urandom);
            a0 = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? iss_addr : AW'($urandom);
            rd_addr  = {a1, a0};
            #3;
            check_model("rnd");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
